// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer.
//   seq_state_e : sequencer FSM states (StIdle .. StDone)
//   HALT_INSN   : buffer word that ends a program without being issued
//   N_BIT/V_BIT/Z_BIT : bit positions of the cpu status flags in last_flags
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitLo,
        StWaitHi,
        StNext,
        StDone
    } seq_state_e;

    localparam logic [15:0] HALT_INSN = 16'hE000;

    localparam int unsigned N_BIT = 2;
    localparam int unsigned V_BIT = 1;
    localparam int unsigned Z_BIT = 0;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Per-instruction watchdog counter for the program sequencer.
//   clk, reset : clock and synchronous active-high reset
//   clr        : zero the count (takes priority over en)
//   en         : count up by one this cycle
//   expired    : count has reached TIMEOUT-1, i.e. this is the last allowed cycle
module seq_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of en so the caller can qualify it by state without a comb loop.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: feeds a cpu one instruction at a time from a small buffer.
// Loads cpu_in/cpu_load, pulses cpu_s, waits for cpu_w to fall and rise again,
// captures cpu_out and {N,V,Z}, then advances until prog_len instructions,
// a HALT word, or a watchdog timeout.
//   clk, reset         : clock, synchronous active-high reset
//   prog_we/addr/data  : buffer write port (honoured only when idle or done)
//   prog_len           : number of instructions to run (0..DEPTH)
//   start              : begin from slot 0 (ignored while busy)
//   cpu_w/out/N/V/Z    : cpu handshake and results
//   cpu_in/load/s      : instruction word, IR load pulse, start pulse
//   pc, busy, done, err: status
//   last_out/last_flags: result of the most recently completed instruction
// Optional macro SEQ_SINGLE_STEP_EN adds input step and output stalled; NEXT
// then holds until step is high.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          cpu_w,
    input  logic [15:0]   cpu_out,
    input  logic          cpu_N,
    input  logic          cpu_V,
    input  logic          cpu_Z,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic          step,
    output logic          stalled,
`endif
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   last_out,
    output logic [2:0]    last_flags
);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   cpu_in_q, cpu_in_d;
    logic          err_q, err_d;
    logic [15:0]   last_out_q, last_out_d;
    logic [2:0]    last_flags_q, last_flags_d;

    logic [15:0]   mem_q [DEPTH];
    logic          mem_we;
    logic [15:0]   cur_word;
    logic          is_halt;
    logic          ctr_clr, ctr_en, ctr_expired;
    logic          advance;

    assign cur_word = mem_q[pc_q];
    assign is_halt  = (cur_word == HALT_INSN);
    assign mem_we   = prog_we && ((state_q == StIdle) || (state_q == StDone));

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = step;
    assign stalled = (state_q == StNext) && !step;
`else
    assign advance = 1'b1;
`endif

    seq_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            cpu_in_q     <= '0;
            err_q        <= 1'b0;
            last_out_q   <= '0;
            last_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cpu_in_q     <= cpu_in_d;
            err_q        <= err_d;
            last_out_q   <= last_out_d;
            last_flags_q <= last_flags_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cpu_in_d     = cpu_in_q;
        err_d        = err_q;
        last_out_d   = last_out_q;
        last_flags_d = last_flags_q;
        ctr_clr      = 1'b0;
        ctr_en       = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    err_d = 1'b0;
                    if (prog_len == '0) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = '0;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (is_halt) begin
                    state_d = StDone;
                end else begin
                    cpu_in_d = cur_word;
                    state_d  = StStart;
                end
            end
            StStart: begin
                ctr_clr = 1'b1;
                state_d = StWaitLo;
            end
            StWaitLo: begin
                ctr_en = 1'b1;
                if (!cpu_w) begin
                    state_d = StWaitHi;
                end else if (ctr_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StWaitHi: begin
                ctr_en = 1'b1;
                // Completion on the final allowed cycle still counts as success.
                if (cpu_w) begin
                    last_out_d          = cpu_out;
                    last_flags_d[N_BIT] = cpu_N;
                    last_flags_d[V_BIT] = cpu_V;
                    last_flags_d[Z_BIT] = cpu_Z;
                    state_d             = StNext;
                end else if (ctr_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StNext: begin
                if (advance) begin
                    if ({1'b0, pc_q} == prog_len - 1'b1) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // cpu_in shows the buffer word during LOAD so the cpu latches it on the load edge.
        cpu_in     = ((state_q == StLoad) && !is_halt) ? cur_word : cpu_in_q;
        cpu_load   = (state_q == StLoad) && !is_halt && !reset;
        cpu_s      = (state_q == StStart) && !reset;
        pc         = pc_q;
        busy       = (state_q != StIdle) && (state_q != StDone);
        done       = (state_q == StDone);
        err        = err_q;
        last_out   = last_out_q;
        last_flags = last_flags_q;
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer. A behavioural cpu stub answers the
// load/s/w handshake and executes MOV-immediate and MOV-shift words; a
// separate reference model predicts registers, last result, pc and pulse counts.
module tb_prog_sequencer;
    import seq_pkg::*;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          cpu_w = 1'b1;
    logic [15:0]   cpu_out = '0;
    logic          cpu_N = 1'b0, cpu_V = 1'b0, cpu_Z = 1'b0;
    logic [15:0]   cpu_in;
    logic          cpu_load, cpu_s, busy, done, err;
    logic [AW-1:0] pc;
    logic [15:0]   last_out;
    logic [2:0]    last_flags;
`ifdef SEQ_SINGLE_STEP_EN
    logic          step = 1'b1;
    logic          stalled;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prog_sequencer #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_len   (prog_len),
        .start      (start),
        .cpu_w      (cpu_w),
        .cpu_out    (cpu_out),
        .cpu_N      (cpu_N),
        .cpu_V      (cpu_V),
        .cpu_Z      (cpu_Z),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
        .stalled    (stalled),
`endif
        .cpu_in     (cpu_in),
        .cpu_load   (cpu_load),
        .cpu_s      (cpu_s),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .last_out   (last_out),
        .last_flags (last_flags)
    );

    // ---------------- instruction semantics ----------------
    function automatic int dest_of(input logic [15:0] w);
        if (w[15:11] == 5'b11010) return int'(w[10:8]);
        if (w[15:11] == 5'b11000) return int'(w[7:5]);
        return -1;
    endfunction

    function automatic logic [15:0] result_of(input logic [15:0] w, input logic [15:0] rm_val);
        if (w[15:11] == 5'b11010) return {{8{w[7]}}, w[7:0]};
        if (w[15:11] == 5'b11000) begin
            case (w[4:3])
                2'd0:    return rm_val;
                2'd1:    return {rm_val[14:0], 1'b0};
                2'd2:    return {1'b0, rm_val[15:1]};
                default: return {rm_val[15], rm_val[15:1]};
            endcase
        end
        return 16'h0000;
    endfunction

    // ---------------- cpu stub ----------------
    logic [15:0] stub_r [8] = '{default: 16'h0000};
    logic [15:0] ir = '0;
    int          stub_cnt = 0;
    bit          stub_hang = 1'b0;
    int          stub_lat_fix = 0;
    int          stub_lat_max = 4;
    int          load_cnt = 0, s_cnt = 0, overlap_cnt = 0, instab_cnt = 0;

    always @(posedge clk) begin
        if (cpu_load) load_cnt <= load_cnt + 1;
        if (cpu_s) s_cnt <= s_cnt + 1;
        if (cpu_load && cpu_s) overlap_cnt <= overlap_cnt + 1;
        if (!reset && !cpu_w && (cpu_in !== ir)) instab_cnt <= instab_cnt + 1;
        if (reset) begin
            cpu_w    <= 1'b1;
            stub_cnt <= 0;
        end else if (cpu_load) begin
            ir <= cpu_in;
        end else if (cpu_s) begin
            if (!stub_hang) begin
                cpu_w    <= 1'b0;
                stub_cnt <= (stub_lat_fix >= 0) ? stub_lat_fix
                                                : int'($urandom_range(stub_lat_max, 0));
            end
        end else if (!cpu_w) begin
            if (stub_cnt == 0) begin
                automatic logic [15:0] r = result_of(ir, stub_r[ir[2:0]]);
                automatic int d = dest_of(ir);
                if (d >= 0) stub_r[d] <= r;
                cpu_out <= r;
                cpu_N   <= r[15];
                cpu_V   <= 1'b0;
                cpu_Z   <= (r == 16'h0000);
                cpu_w   <= 1'b1;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] prog_m [DEPTH];
    logic [15:0] model_r [8] = '{default: 16'h0000};
    logic [15:0] exp_last_out = '0;
    logic [2:0]  exp_last_flags = '0;
    int          m_pc = 0;

    task automatic model_run(input int len, output int exp_loads);
        exp_loads = 0;
        for (int i = 0; i < len; i++) begin
            automatic logic [15:0] w = prog_m[i];
            automatic logic [15:0] r;
            automatic int d;
            m_pc = i;
            if (w == HALT_INSN) break;
            exp_loads++;
            r = result_of(w, model_r[w[2:0]]);
            d = dest_of(w);
            if (d >= 0) model_r[d] = r;
            exp_last_out   = r;
            exp_last_flags = {r[15], 1'b0, r == 16'h0000};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic write_slot(input int a, input logic [15:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic load_prog(input int len);
        for (int i = 0; i < len; i++) write_slot(i, prog_m[i]);
    endtask

    task automatic start_run(input int len);
        @(negedge clk);
        prog_len = (AW + 1)'(len);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({busy, done, err, cpu_load, cpu_s} !== 5'b0) begin
            fails++; $display("FAIL reset_ctl: got %b want 00000", {busy, done, err, cpu_load, cpu_s});
        end
        tests++; if (pc !== '0 || cpu_in !== 16'h0) begin
            fails++; $display("FAIL reset_pc_in: got pc=%0d in=%h want 0/0000", pc, cpu_in);
        end
        tests++; if (last_out !== 16'h0 || last_flags !== 3'b0) begin
            fails++; $display("FAIL reset_last: got %h/%b want 0000/000", last_out, last_flags);
        end
        @(negedge clk);
        reset = 1'b0;
        // Reset during LOAD must suppress the load pulse in that same cycle.
        write_slot(0, 16'hD00A);
        start_run(1);
        reset = 1'b1;
        #1;
        tests++; if (cpu_load !== 1'b0) begin
            fails++; $display("FAIL reset_drops_load: got %b want 0", cpu_load);
        end
        @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0 || load_cnt !== 0) begin
            fails++; $display("FAIL reset_in_load: got busy=%b loads=%0d want 0/0", busy, load_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_pair;
        bit ok; int cyc, el, l0, s0;
        stub_lat_fix = 0;
        prog_m[0] = 16'hD146;
        prog_m[1] = 16'hD202;
        load_prog(2);
        model_run(2, el);
        l0 = load_cnt; s0 = s_cnt;
        start_run(2);
        wait_done(ok, cyc);
        tests++; if (!ok || err !== 1'b0) begin
            fails++; $display("FAIL pair_done: got done=%b err=%b want 1/0", ok, err);
        end
        tests++; if (stub_r[1] !== 16'd70 || stub_r[2] !== 16'd2) begin
            fails++; $display("FAIL pair_regs: got R1=%0d R2=%0d want 70/2", stub_r[1], stub_r[2]);
        end
        tests++; if (last_out !== 16'd2 || last_flags !== 3'b000) begin
            fails++; $display("FAIL pair_last: got %h/%b want 0002/000", last_out, last_flags);
        end
        tests++; if (load_cnt - l0 !== 2 || s_cnt - s0 !== 2) begin
            fails++; $display("FAIL pair_pulses: got load=%0d s=%0d want 2/2", load_cnt - l0, s_cnt - s0);
        end
        // Each instruction: LOAD + START, two wait cycles for a zero-latency cpu, NEXT.
        tests++; if (cyc !== 2 * (2 + 2 + 1)) begin
            fails++; $display("FAIL pair_latency: got %0d want %0d", cyc, 2 * (2 + 2 + 1));
        end
        tests++; if (pc !== AW'(1)) begin
            fails++; $display("FAIL pair_pc: got %0d want 1", pc);
        end
    endtask

    task automatic test_shift;
        bit ok; int cyc, el;
        prog_m[0] = 16'hD00A;
        prog_m[1] = 16'hC028;
        load_prog(2);
        model_run(2, el);
        start_run(2);
        wait_done(ok, cyc);
        tests++; if (!ok || last_out !== 16'd20 || stub_r[1] !== 16'd20) begin
            fails++; $display("FAIL shift: got done=%b out=%0d R1=%0d want 1/20/20", ok, last_out, stub_r[1]);
        end
    endtask

    task automatic test_halt;
        bit ok; int cyc, el, l0;
        logic [15:0] r1_before;
        r1_before = stub_r[1];
        prog_m[0] = 16'hD00A;
        prog_m[1] = HALT_INSN;
        prog_m[2] = 16'hD105;
        load_prog(3);
        model_run(3, el);
        l0 = load_cnt;
        start_run(3);
        wait_done(ok, cyc);
        tests++; if (!ok || pc !== AW'(1)) begin
            fails++; $display("FAIL halt_pc: got done=%b pc=%0d want 1/1", ok, pc);
        end
        tests++; if (load_cnt - l0 !== 1) begin
            fails++; $display("FAIL halt_loads: got %0d want 1", load_cnt - l0);
        end
        tests++; if (stub_r[1] !== r1_before || last_out !== 16'd10 || err !== 1'b0) begin
            fails++; $display("FAIL halt_state: got R1=%0d out=%0d err=%b want %0d/10/0",
                              stub_r[1], last_out, err, r1_before);
        end
    endtask

    task automatic test_zero_len;
        bit ok; int cyc, l0;
        l0 = load_cnt;
        start_run(0);
        wait_done(ok, cyc);
        tests++; if (!ok || err !== 1'b0 || load_cnt - l0 !== 0 || pc !== AW'(m_pc)) begin
            fails++; $display("FAIL zero_len: got done=%b err=%b loads=%0d pc=%0d want 1/0/0/%0d",
                              ok, err, load_cnt - l0, pc, m_pc);
        end
    endtask

    task automatic test_timeout;
        bit ok, seen; int cyc, k, el;
        stub_hang = 1'b1;
        prog_m[0] = 16'hD30C;
        load_prog(1);
        start_run(1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_s === 1'b1) begin seen = 1'b1; break; end
        end
        @(posedge clk); // state becomes WAIT_LO on this edge
        k = 0;
        for (int i = 1; i <= TIMEOUT + 8; i++) begin
            @(posedge clk);
            #1;
            k = i;
            if (done === 1'b1) break;
        end
        tests++; if (!seen || k !== TIMEOUT || err !== 1'b1) begin
            fails++; $display("FAIL timeout: got s_seen=%b cycles=%0d err=%b want 1/%0d/1",
                              seen, k, err, TIMEOUT);
        end
        stub_hang = 1'b0;
        reset = 1'b1; // clear the stub's pending instruction; DUT restarts from IDLE
        @(negedge clk);
        reset = 1'b0;
        exp_last_out = '0; exp_last_flags = '0;
        model_run(1, el);
        start_run(1);
        wait_done(ok, cyc);
        tests++; if (!ok || err !== 1'b0 || last_out !== exp_last_out) begin
            fails++; $display("FAIL timeout_recover: got done=%b err=%b out=%h want 1/0/%h",
                              ok, err, last_out, exp_last_out);
        end
        // Timeout, then restart from DONE without reset must also clear err.
        stub_hang = 1'b1;
        start_run(1);
        wait_done(ok, cyc);
        stub_hang = 1'b0;
        tests++; if (!ok || err !== 1'b1) begin
            fails++; $display("FAIL timeout_again: got done=%b err=%b want 1/1", ok, err);
        end
        @(negedge clk);
        start = 1'b1; prog_len = '0;
        @(negedge clk);
        start = 1'b0;
        tests++; if (err !== 1'b0 || done !== 1'b1) begin
            fails++; $display("FAIL restart_clears_err: got err=%b done=%b want 0/1", err, done);
        end
    endtask

    task automatic test_write_while_busy;
        bit ok; int cyc, el;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_last_out = '0; exp_last_flags = '0; m_pc = 0;
        stub_lat_fix = 0;
        prog_m[0] = 16'hD311;
        prog_m[1] = 16'hD422;
        load_prog(2);
        model_run(2, el);
        start_run(2);
        write_slot(1, 16'hD4FF);
        wait_done(ok, cyc);
        tests++; if (!ok || stub_r[4] !== 16'h0022 || last_out !== 16'h0022) begin
            fails++; $display("FAIL write_busy: got done=%b R4=%h out=%h want 1/0022/0022",
                              ok, stub_r[4], last_out);
        end
    endtask

    task automatic test_reset_mid;
        bit ok, seen; int cyc, el, l0, nsp;
        stub_lat_fix = 6;
        prog_m[0] = 16'hD533;
        prog_m[1] = 16'hD644;
        prog_m[2] = 16'hD755;
        load_prog(3);
        start_run(3);
        nsp = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_s === 1'b1) nsp++;
            if (nsp == 2 && cpu_w === 1'b0) begin seen = 1'b1; break; end
        end
        @(negedge clk); // now in WAIT_HI of slot 1
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (!seen || busy !== 1'b0 || pc !== '0 || cpu_s !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_mid: got seen=%b busy=%b pc=%0d s=%b done=%b want 1/0/0/0/0",
                              seen, busy, pc, cpu_s, done);
        end
        tests++; if (last_out !== 16'h0) begin
            fails++; $display("FAIL reset_mid_last: got %h want 0000", last_out);
        end
        @(negedge clk);
        reset = 1'b0;
        stub_lat_fix = -1;
        exp_last_out = '0; exp_last_flags = '0;
        model_run(3, el);
        l0 = load_cnt;
        start_run(3);
        wait_done(ok, cyc);
        tests++; if (!ok || load_cnt - l0 !== 3 || pc !== AW'(2) || last_out !== 16'h0055) begin
            fails++; $display("FAIL rerun: got done=%b loads=%0d pc=%0d out=%h want 1/3/2/0055",
                              ok, load_cnt - l0, pc, last_out);
        end
        tests++; if (stub_r[5] !== 16'h0033 || stub_r[6] !== 16'h0044 || stub_r[7] !== 16'h0055) begin
            fails++; $display("FAIL rerun_regs: got %h %h %h want 0033 0044 0055",
                              stub_r[5], stub_r[6], stub_r[7]);
        end
    endtask

    task automatic test_random;
        bit ok; int cyc, el, len, l0, s0, k;
        stub_lat_fix = -1;
        // Sync the model to the cpu's registers left by earlier directed runs.
        for (int r = 0; r < 8; r++) model_r[r] = stub_r[r];
        for (int it = 0; it < 20; it++) begin
            len = int'($urandom_range(DEPTH, 1));
            for (int i = 0; i < len; i++) begin
                k = int'($urandom_range(11, 0));
                if (k == 0) prog_m[i] = HALT_INSN;
                else if (k < 6) prog_m[i] = {5'b11010, 3'($urandom_range(7, 0)), 8'($urandom)};
                else prog_m[i] = {5'b11000, 3'b000, 3'($urandom_range(7, 0)),
                                  2'($urandom_range(3, 0)), 3'($urandom_range(7, 0))};
            end
            load_prog(len);
            model_run(len, el);
            l0 = load_cnt; s0 = s_cnt;
            start_run(len);
            wait_done(ok, cyc);
            tests++; if (!ok || err !== 1'b0 || pc !== AW'(m_pc)) begin
                fails++; $display("FAIL rand%0d_end: got done=%b err=%b pc=%0d want 1/0/%0d",
                                  it, ok, err, pc, m_pc);
            end
            tests++; if (last_out !== exp_last_out || last_flags !== exp_last_flags) begin
                fails++; $display("FAIL rand%0d_last: got %h/%b want %h/%b",
                                  it, last_out, last_flags, exp_last_out, exp_last_flags);
            end
            tests++; if (load_cnt - l0 !== el || s_cnt - s0 !== el) begin
                fails++; $display("FAIL rand%0d_pulses: got load=%0d s=%0d want %0d",
                                  it, load_cnt - l0, s_cnt - s0, el);
            end
            for (int r = 0; r < 8; r++) begin
                tests++; if (stub_r[r] !== model_r[r]) begin
                    fails++; $display("FAIL rand%0d_R%0d: got %h want %h", it, r, stub_r[r], model_r[r]);
                end
            end
        end
        tests++; if (overlap_cnt !== 0 || instab_cnt !== 0) begin
            fails++; $display("FAIL handshake: got overlap=%0d unstable_in=%0d want 0/0",
                              overlap_cnt, instab_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_pair;
        test_shift;
        test_halt;
        test_zero_len;
        test_timeout;
        test_write_while_busy;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
